input_port_debouncer: RTL

Upstream stage of the 4-bit CPU datapath. Conditions the raw external switch inputs into a clean 4-bit word. That word drives the ALU source selector's input-port leg (select code 2), replacing the hard-wired 4'b0101 constant. The block performs per-bit 2-flop synchronisation and whole-word debounce. It also reports changes through a one-cycle strobe and a sticky pending flag that the CPU side acknowledges.

---
 rtl/input_port_debouncer_pkg.sv | 29 ++
 rtl/input_port_debouncer_sync_2ff.sv | 33 +++
 rtl/input_port_debouncer.sv | 82 ++++++++
 3 files changed

// File: rtl/input_port_debouncer_pkg.sv
// rtl/input_port_debouncer_pkg.sv - shared constants and debounce action type for the input port
package input_port_debouncer_pkg;

    localparam logic [1:0] SEL_IN      = 2'd2;
    localparam int         IN_WIDTH    = 4;
    localparam int         IN_DEBOUNCE = 4;

    typedef enum logic [1:0] {
        DB_SETTLED,
        DB_RESTART,
        DB_COUNT,
        DB_ACCEPT
    } db_action_e;

    // Restart outranks everything: a moving word never advances the count.
    function automatic db_action_e db_classify(
        input logic s_differs,
        input logic cand_is_new,
        input logic cnt_done
    );
        if (s_differs) begin
            return DB_RESTART;
        end else if (cand_is_new) begin
            return cnt_done ? DB_ACCEPT : DB_COUNT;
        end
        return DB_SETTLED;
    endfunction

endpackage

// File: rtl/input_port_debouncer_sync_2ff.sv
// rtl/input_port_debouncer_sync_2ff.sv - two-stage synchroniser for asynchronous level inputs
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] sync1_d;
    logic [WIDTH-1:0] sync2_d;

    always_comb begin
        sync1_d = D;
        sync2_d = sync1_q;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign Q = sync2_q;

endmodule

// File: rtl/input_port_debouncer.sv
// rtl/input_port_debouncer.sv - synchronised whole-word switch debouncer with change strobe and sticky flag
module input_port_debouncer
    import input_port_debouncer_pkg::*;
#(
    parameter int WIDTH    = IN_WIDTH,
    parameter int DEBOUNCE = IN_DEBOUNCE,
    parameter int CNT_W    = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SW,
    input  logic             ACK,
    output logic [WIDTH-1:0] IN_DATA,
    output logic             CHG,
    output logic             CHG_PEND
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] in_data_q, in_data_d;
    logic             chg_q, chg_d;
    logic             chg_pend_q, chg_pend_d;
    db_action_e       action;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .CK  (CK),
        .RST (RST),
        .D   (SW),
        .Q   (s)
    );

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        in_data_d = in_data_q;
        chg_d     = 1'b0;
        action    = db_classify(s != cand_q, cand_q != in_data_q, cnt_q == CNT_LAST);
        unique case (action)
            DB_RESTART: begin
                cand_d = s;
                cnt_d  = '0;
            end
            DB_COUNT: begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            DB_ACCEPT: begin
                in_data_d = cand_q;
                cnt_d     = '0;
                chg_d     = 1'b1;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        // A strobe sampled together with ACK keeps the flag set.
        chg_pend_d = chg_q | (chg_pend_q & ~ACK);
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            cand_q     <= '0;
            cnt_q      <= '0;
            in_data_q  <= '0;
            chg_q      <= 1'b0;
            chg_pend_q <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            in_data_q  <= in_data_d;
            chg_q      <= chg_d;
            chg_pend_q <= chg_pend_d;
        end
    end

    assign IN_DATA  = in_data_q;
    assign CHG      = chg_q;
    assign CHG_PEND = chg_pend_q;

endmodule
